// File: rtl/spi_slave_io.sv
// rtl/spi_slave_io.sv - SPI responder (mode: idle low, MOSI sampled on SCK rise) with 8-bit CPU register port
// Optional feature macro: SPIS_IRQ_EN (RX-ready / ss-release interrupt).
module spi_slave_io #(
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] AD,
  input  logic [7:0] DI,
  output logic [7:0] DO,
  input  logic       rw,
  input  logic       cs,
  output logic       irq,
  input  logic       sck,
  input  logic       mosi,
  input  logic       ss,
  output logic       miso,
  output logic       miso_oe
);

  logic [SYNC_STAGES-1:0] sck_sync, mosi_sync, ss_sync;
  logic                   sck_prev, ss_prev;
  logic                   sck_s, mosi_s, ss_s;

  always_ff @(posedge clk) begin
    if (rst) begin
      sck_sync  <= '0;
      mosi_sync <= '0;
      ss_sync   <= '1;
      sck_prev  <= 1'b0;
      ss_prev   <= 1'b1;
    end else begin
      sck_sync  <= {sck_sync[SYNC_STAGES-2:0], sck};
      mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], mosi};
      ss_sync   <= {ss_sync[SYNC_STAGES-2:0], ss};
      sck_prev  <= sck_s;
      ss_prev   <= ss_s;
    end
  end

  assign sck_s  = sck_sync[SYNC_STAGES-1];
  assign mosi_s = mosi_sync[SYNC_STAGES-1];
  assign ss_s   = ss_sync[SYNC_STAGES-1];

  logic ss_fall, ss_rise, sck_rise_act, sck_fall_act;
  assign ss_fall      = ss_prev & ~ss_s;
  assign ss_rise      = ~ss_prev & ss_s;
  assign sck_rise_act = sck_s & ~sck_prev & ~ss_s & ~ss_fall;
  assign sck_fall_act = ~sck_s & sck_prev & ~ss_s & ~ss_fall;

  logic rd_sel, wr_sel, rd0, rd1, wr0, wr1, wr3;
  assign rd_sel = cs & rw;
  assign wr_sel = cs & ~rw;
  assign rd0    = rd_sel && (AD == 2'd0);
  assign rd1    = rd_sel && (AD == 2'd1);
  assign wr0    = wr_sel && (AD == 2'd0);
  assign wr1    = wr_sel && (AD == 2'd1);
  assign wr3    = wr_sel && (AD == 2'd3);

  logic [7:0] rx_shift, rx_data, tx_shift, tx_hold, def_byte, byte_cnt;
  logic [3:0] bit_cnt;
  logic       rdy, txf, ovr, und;
  logic       ie_rx, ie_ss;
  logic       byte_done, reload, rdy_held;
  logic [7:0] rx_byte;

  assign rx_byte   = {rx_shift[6:0], mosi_s};
  assign byte_done = sck_rise_act && (bit_cnt == 4'd7);
  assign reload    = ss_fall | (sck_fall_act && (bit_cnt == 4'd8));
  // A $0 read in the completion cycle frees the buffer, so the new byte lands instead of overrunning.
  assign rdy_held  = rdy & ~rd0;

  always_ff @(posedge clk) begin
    if (rst) begin
      bit_cnt  <= 4'd0;
      byte_cnt <= 8'd0;
      rx_shift <= 8'd0;
      rx_data  <= 8'hFF;
      tx_shift <= 8'hFF;
      tx_hold  <= 8'h00;
      def_byte <= 8'hFF;
      miso_oe  <= 1'b0;
      rdy      <= 1'b0;
      txf      <= 1'b0;
      ovr      <= 1'b0;
      und      <= 1'b0;
      DO       <= 8'h00;
    end else begin
      if (ss_fall) begin
        bit_cnt  <= 4'd0;
        byte_cnt <= 8'd0;
        miso_oe  <= 1'b1;
      end else if (ss_rise) begin
        bit_cnt  <= 4'd0;
        miso_oe  <= 1'b0;
      end else if (sck_rise_act) begin
        rx_shift <= rx_byte;
        bit_cnt  <= bit_cnt + 4'd1;
        if (bit_cnt == 4'd7) byte_cnt <= byte_cnt + 8'd1;
      end else if (sck_fall_act && (bit_cnt == 4'd8)) begin
        bit_cnt <= 4'd0;
      end

      if (reload) tx_shift <= txf ? tx_hold : def_byte;
      else if (sck_fall_act) tx_shift <= {tx_shift[6:0], 1'b1};

      if (wr0) txf <= 1'b1;
      else if (reload && txf) txf <= 1'b0;
      if (wr0) tx_hold <= DI;
      if (wr3) def_byte <= DI;

      if (byte_done && !rdy_held) begin
        rx_data <= rx_byte;
        rdy     <= 1'b1;
      end else if (rd0) begin
        rdy <= 1'b0;
      end

      if (byte_done && rdy_held) ovr <= 1'b1;
      else if (wr1 && DI[5]) ovr <= 1'b0;

      if (reload && !txf) und <= 1'b1;
      else if (wr1 && DI[4]) und <= 1'b0;

      if (rd_sel) begin
        case (AD)
          2'd0: DO <= rx_data;
          2'd1: DO <= {rdy, txf, ovr, und, ~ss_s, 1'b0, ie_rx, ie_ss};
          2'd2: DO <= byte_cnt;
          default: DO <= def_byte;
        endcase
      end
    end
  end

  assign miso = miso_oe ? tx_shift[7] : 1'b1;

`ifdef SPIS_IRQ_EN
  logic ss_rise_latch;
  always_ff @(posedge clk) begin
    if (rst) begin
      ie_rx         <= 1'b0;
      ie_ss         <= 1'b0;
      ss_rise_latch <= 1'b0;
    end else begin
      if (wr1) {ie_rx, ie_ss} <= DI[1:0];
      if (ss_rise) ss_rise_latch <= 1'b1;
      else if (rd1) ss_rise_latch <= 1'b0;
    end
  end
  assign irq = (ie_rx & rdy) | (ie_ss & ss_rise_latch);
`else
  assign ie_rx = 1'b0;
  assign ie_ss = 1'b0;
  assign irq   = 1'b0;
`endif

endmodule

// File: tb/tb_spi_slave_io.sv
// tb/tb_spi_slave_io.sv - bench for spi_slave_io: bench acts as SPI master and CPU
module tb_spi_slave_io;
  localparam int HALF = 8;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] AD;
  logic [7:0] DI, DO;
  logic       rw, cs, irq, sck, mosi, ss, miso, miso_oe;

  int checks = 0;
  int failures = 0;
  logic [7:0] exp_q[$];

  spi_slave_io #(.SYNC_STAGES(2)) dut (
    .clk(clk), .rst(rst), .AD(AD), .DI(DI), .DO(DO), .rw(rw), .cs(cs), .irq(irq),
    .sck(sck), .mosi(mosi), .ss(ss), .miso(miso), .miso_oe(miso_oe)
  );

  always #5 clk = ~clk;

  task automatic cpu_write(input logic [1:0] a, input logic [7:0] d);
    @(negedge clk);
    cs = 1'b1; rw = 1'b0; AD = a; DI = d;
    @(negedge clk);
    cs = 1'b0; rw = 1'b1;
  endtask

  task automatic cpu_read(input logic [1:0] a, output logic [7:0] d);
    @(negedge clk);
    cs = 1'b1; rw = 1'b1; AD = a;
    @(negedge clk);
    cs = 1'b0;
    d = DO;
  endtask

  task automatic spi_byte(input logic [7:0] tx, input bit collide,
                          output logic [7:0] rx, output logic [7:0] col_do);
    logic [7:0] t;
    t = tx;
    col_do = 8'h00;
    mosi = t[7];
    for (int i = 7; i >= 0; i--) begin
      repeat (HALF) @(negedge clk);
      sck = 1'b1;
      if (collide && i == 0) begin
        repeat (2) @(negedge clk);
        cs = 1'b1; rw = 1'b1; AD = 2'd0;
        @(negedge clk);
        cs = 1'b0;
        col_do = DO;
        repeat (HALF - 3) @(negedge clk);
      end else begin
        repeat (HALF) @(negedge clk);
      end
      rx[i] = miso;
      sck = 1'b0;
      if (i > 0) mosi = t[i-1];
    end
  endtask

  task automatic ss_low();
    ss = 1'b0;
    repeat (HALF) @(negedge clk);
  endtask

  task automatic ss_high();
    repeat (HALF) @(negedge clk);
    ss = 1'b1;
    repeat (HALF) @(negedge clk);
  endtask

  task automatic test_reset();
    logic [7:0] v;
    logic [7:0] exp_rd[4];
    exp_rd[0] = 8'hFF; exp_rd[1] = 8'h00; exp_rd[2] = 8'h00; exp_rd[3] = 8'hFF;
    rst = 1'b1;
    repeat (4) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (DO !== 8'h00) begin failures++; $display("FAIL reset_do got=%h exp=00", DO); end
    checks++;
    if (miso !== 1'b1 || miso_oe !== 1'b0 || irq !== 1'b0) begin
      failures++; $display("FAIL reset_pins got miso=%b oe=%b irq=%b exp 1 0 0", miso, miso_oe, irq);
    end
    for (int a = 0; a < 4; a++) begin
      cpu_read(a[1:0], v);
      checks++;
      if (v !== exp_rd[a]) begin failures++; $display("FAIL reset_rd%0d got=%h exp=%h", a, v, exp_rd[a]); end
    end
  endtask

  task automatic test_tx_rx();
    logic [7:0] v, m, c, e;
    cpu_write(2'd0, 8'hA5);
    cpu_read(2'd1, v);
    checks++;
    if (v !== 8'h40) begin failures++; $display("FAIL txf_set got=%h exp=40", v); end
    ss_low();
    checks++;
    if (miso_oe !== 1'b1) begin failures++; $display("FAIL oe_on got=%b exp=1", miso_oe); end
    exp_q.push_back(8'hA5);
    spi_byte(8'h3C, 1'b0, m, c);
    e = exp_q.pop_front();
    checks++;
    if (m !== e) begin failures++; $display("FAIL miso_a5 got=%h exp=%h", m, e); end
    ss_high();
    cpu_read(2'd1, v);
    checks++;
    if (v !== 8'h90) begin failures++; $display("FAIL stat_rdy got=%h exp=90", v); end
    cpu_read(2'd0, v);
    checks++;
    if (v !== 8'h3C) begin failures++; $display("FAIL rx_3c got=%h exp=3c", v); end
    cpu_read(2'd1, v);
    checks++;
    if (v !== 8'h10) begin failures++; $display("FAIL stat_rdy_clr got=%h exp=10", v); end
  endtask

  task automatic test_underrun_overrun();
    logic [7:0] v, m, c, e;
    logic [7:0] tx[3];
    tx[0] = 8'h11; tx[1] = 8'h22; tx[2] = 8'h33;
    cpu_write(2'd1, 8'h30);
    ss_low();
    for (int i = 0; i < 3; i++) begin
      exp_q.push_back(8'hFF);
      spi_byte(tx[i], 1'b0, m, c);
      e = exp_q.pop_front();
      checks++;
      if (m !== e) begin failures++; $display("FAIL miso_dflt%0d got=%h exp=%h", i, m, e); end
    end
    ss_high();
    cpu_read(2'd1, v);
    checks++;
    if (v !== 8'hB0) begin failures++; $display("FAIL stat_ovr_und got=%h exp=b0", v); end
    cpu_read(2'd0, v);
    checks++;
    if (v !== 8'h11) begin failures++; $display("FAIL rx_kept got=%h exp=11", v); end
    cpu_read(2'd2, v);
    checks++;
    if (v !== 8'h03) begin failures++; $display("FAIL byte_cnt3 got=%h exp=03", v); end
    cpu_write(2'd1, 8'h30);
    cpu_read(2'd1, v);
    checks++;
    if (v !== 8'h00) begin failures++; $display("FAIL stat_clr got=%h exp=00", v); end
  endtask

  task automatic test_partial();
    logic [7:0] v, m, c, e;
    ss_low();
    mosi = 1'b1;
    for (int i = 0; i < 5; i++) begin
      repeat (HALF) @(negedge clk); sck = 1'b1;
      repeat (HALF) @(negedge clk); sck = 1'b0;
    end
    ss_high();
    checks++;
    if (miso !== 1'b1 || miso_oe !== 1'b0) begin
      failures++; $display("FAIL partial_pins got miso=%b oe=%b exp 1 0", miso, miso_oe);
    end
    cpu_read(2'd1, v);
    checks++;
    if (v !== 8'h10) begin failures++; $display("FAIL partial_stat got=%h exp=10", v); end
    cpu_read(2'd2, v);
    checks++;
    if (v !== 8'h00) begin failures++; $display("FAIL partial_cnt got=%h exp=00", v); end
    ss_low();
    exp_q.push_back(8'hFF);
    spi_byte(8'h5A, 1'b0, m, c);
    e = exp_q.pop_front();
    checks++;
    if (m !== e) begin failures++; $display("FAIL miso_5a got=%h exp=%h", m, e); end
    ss_high();
    cpu_read(2'd0, v);
    checks++;
    if (v !== 8'h5A) begin failures++; $display("FAIL rx_5a got=%h exp=5a", v); end
  endtask

  task automatic test_back_to_back();
    logic [7:0] v, m, c;
    cpu_write(2'd1, 8'h30);
    ss_low();
    spi_byte(8'h77, 1'b0, m, c);
    ss_high();
    cpu_read(2'd0, v);
    checks++;
    if (v !== 8'h77) begin failures++; $display("FAIL rx_77 got=%h exp=77", v); end
    ss_low();
    spi_byte(8'h99, 1'b1, m, c);
    ss_high();
    checks++;
    if (c !== 8'h77) begin failures++; $display("FAIL collide_old got=%h exp=77", c); end
    cpu_read(2'd1, v);
    checks++;
    if (v[7] !== 1'b1 || v[5] !== 1'b0) begin
      failures++; $display("FAIL collide_stat got rdy=%b ovr=%b exp rdy=1 ovr=0", v[7], v[5]);
    end
    cpu_read(2'd0, v);
    checks++;
    if (v !== 8'h99) begin failures++; $display("FAIL collide_new got=%h exp=99", v); end
  endtask

  task automatic test_irq();
    logic [7:0] v, m, c;
    cpu_write(2'd1, 8'h33);
    cpu_read(2'd1, v);
`ifdef SPIS_IRQ_EN
    checks++;
    if (v[1:0] !== 2'b11) begin failures++; $display("FAIL ie_rd got=%b exp=11", v[1:0]); end
    ss_low();
    spi_byte(8'hC3, 1'b0, m, c);
    repeat (HALF) @(negedge clk);
    checks++;
    if (irq !== 1'b1) begin failures++; $display("FAIL irq_rx got=%b exp=1", irq); end
    cpu_read(2'd0, v);
    checks++;
    if (irq !== 1'b0) begin failures++; $display("FAIL irq_rx_clr got=%b exp=0", irq); end
    ss_high();
    checks++;
    if (irq !== 1'b1) begin failures++; $display("FAIL irq_ss got=%b exp=1", irq); end
    cpu_read(2'd1, v);
    checks++;
    if (irq !== 1'b0) begin failures++; $display("FAIL irq_ss_clr got=%b exp=0", irq); end
`else
    checks++;
    if (v[1:0] !== 2'b00) begin failures++; $display("FAIL ie_rd got=%b exp=00", v[1:0]); end
    ss_low();
    spi_byte(8'hC3, 1'b0, m, c);
    ss_high();
    checks++;
    if (irq !== 1'b0) begin failures++; $display("FAIL irq_off got=%b exp=0", irq); end
`endif
  endtask

  initial begin
    rst = 1'b1; AD = 2'd0; DI = 8'h00; rw = 1'b1; cs = 1'b0;
    sck = 1'b0; mosi = 1'b0; ss = 1'b1;
    test_reset();
    test_tx_rx();
    test_underrun_overrun();
    test_partial();
    test_back_to_back();
    test_irq();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
